// File: rtl/misaligned_load_unit_pkg.sv
// Shared load-path types: truncation kinds, load FSM states and access sizing.
`ifndef XLEN
`define XLEN 32
`endif

package misaligned_load_unit_pkg;

  typedef enum logic [2:0] {
    BYTE,
    HALF_WORD,
    WORD,
    DOUBLE_WORD,
    BYTE_UNSIGNED,
    HALF_WORD_UNSIGNED,
    WORD_UNSIGNED,
    NO_TRUNC
  } truncType;

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} loadState;

  // Access size in bytes; NO_TRUNC covers the full data width.
  function automatic logic [3:0] accessSize(input truncType t, input int unsigned xlen);
    case (t)
      BYTE, BYTE_UNSIGNED:           return 4'd1;
      HALF_WORD, HALF_WORD_UNSIGNED: return 4'd2;
      WORD, WORD_UNSIGNED:           return 4'd4;
      DOUBLE_WORD:                   return 4'd8;
      default:                       return 4'(xlen / 8);
    endcase
  endfunction

  function automatic logic isSigned(input truncType t);
    return (t == BYTE) || (t == HALF_WORD) || (t == WORD) || (t == DOUBLE_WORD);
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load extraction: shift a two-beat window down by the byte
// offset, keep the access-size low bytes and sign- or zero-extend them.
module load_extract
  import misaligned_load_unit_pkg::*;
#(
  parameter int XLEN = `XLEN,
  localparam int OFFW = $clog2(XLEN/8)
) (
  input  logic [2*XLEN-1:0] window,
  input  logic [OFFW-1:0]   offset,
  input  truncType          ttype,
  output logic [XLEN-1:0]   result
);

  logic [XLEN-1:0] low;
  logic [3:0]      size;
  logic            fill;

  assign low = XLEN'(window >> {offset, 3'b000});

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; that is what keeps a latch from being inferred.
  always_comb begin
    size   = accessSize(ttype, XLEN);
    fill   = 1'b0;
    result = low;
    for (int b = 0; b < XLEN/8; b++) begin
      if (b == int'(size) - 1) fill = isSigned(ttype) & low[8*b+7];
    end
    for (int b = 0; b < XLEN/8; b++) begin
      if (b >= int'(size)) result[8*b +: 8] = {8{fill}};
    end
  end

endmodule

// File: rtl/misaligned_load_unit.sv
// Sequential load alignment unit: one or two memory beats per load, result
// returned through a valid/ready handshake, unsplittable loads fault.
module misaligned_load_unit
  import misaligned_load_unit_pkg::*;
#(
  parameter int XLEN = `XLEN,
  parameter bit SPLIT_MISALIGNED = 1'b1,
  localparam int OFFW = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ReqValid,
  output logic            ReqReady,
  input  truncType        ReqType,
  input  logic [OFFW-1:0] ReqOffset,
  output logic            MemReqValid,
  output logic            MemReqSecond,
  input  logic            MemReqReady,
  input  logic            MemRspValid,
  input  logic [XLEN-1:0] MemRspData,
  output logic            RespValid,
  input  logic            RespReady,
  output logic [XLEN-1:0] RespData,
  output logic            RespFault
);

  loadState        state_q, state_d;
  truncType        type_q;
  logic [OFFW-1:0] offset_q;
  logic [XLEN-1:0] beat0_q, resp_data_q;
  logic            cross_q, resp_fault_q;

  logic [3:0]        req_size;
  logic              req_cross, req_misaligned, req_fault, req_fire;
  logic [2*XLEN-1:0] window;
  logic [XLEN-1:0]   extracted;

  always_comb begin
    req_size       = accessSize(ReqType, XLEN);
    req_cross      = (int'(ReqOffset) + int'(req_size)) > XLEN/8;
    req_misaligned = (int'(ReqOffset) & (int'(req_size) - 1)) != 0;
    // A 32-bit build has no doubleword, and an unsigned word needs no zero-extension there.
    req_fault      = (!SPLIT_MISALIGNED && req_misaligned) ||
                     ((XLEN == 32) && (ReqType == DOUBLE_WORD || ReqType == WORD_UNSIGNED));
  end

  // Upper beat is zero unless the load spans into the next aligned word.
  assign window = (state_q == RSP1) ? {MemRspData, beat0_q} : {{XLEN{1'b0}}, MemRspData};

  load_extract #(.XLEN(XLEN)) u_extract (
    .window (window),
    .offset (offset_q),
    .ttype  (type_q),
    .result (extracted)
  );

  always_comb begin
    state_d      = state_q;
    ReqReady     = (state_q == IDLE) || (state_q == DONE && RespReady);
    MemReqValid  = (state_q == REQ0) || (state_q == REQ1);
    MemReqSecond = (state_q == REQ1);
    RespValid    = (state_q == DONE);
    case (state_q)
      IDLE: if (ReqValid) state_d = req_fault ? DONE : REQ0;
      REQ0: if (MemReqReady) state_d = RSP0;
      RSP0: if (MemRspValid) state_d = cross_q ? REQ1 : DONE;
      REQ1: if (MemReqReady) state_d = RSP1;
      RSP1: if (MemRspValid) state_d = DONE;
      DONE: if (RespReady) state_d = ReqValid ? (req_fault ? DONE : REQ0) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_fire = ReqValid && ReqReady;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      type_q       <= BYTE;
      offset_q     <= '0;
      cross_q      <= 1'b0;
      beat0_q      <= '0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        type_q       <= ReqType;
        offset_q     <= ReqOffset;
        cross_q      <= req_cross;
        resp_fault_q <= req_fault;
        resp_data_q  <= '0;
      end
      if (state_q == RSP0 && MemRspValid) beat0_q <= MemRspData;
      if (MemRspValid && ((state_q == RSP0 && !cross_q) || state_q == RSP1))
        resp_data_q <= extracted;
    end
  end

  assign RespData  = resp_data_q;
  assign RespFault = resp_fault_q;

endmodule

// File: tb/tb_misaligned_load_unit.sv
// Self-checking bench: scoreboarded loads on a 32-bit split unit, plus directed
// checks on a non-splitting 32-bit unit and a 64-bit unit.
module tb_misaligned_load_unit;
  import misaligned_load_unit_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- main DUT: XLEN=32, split ----------------
  logic ReqValid, ReqReady, MemReqValid, MemReqSecond, MemReqReady;
  logic MemRspValid, RespValid, RespReady, RespFault;
  truncType ReqType;
  logic [1:0] ReqOffset;
  logic [31:0] MemRspData, RespData;

  misaligned_load_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqType(ReqType), .ReqOffset(ReqOffset), .MemReqValid(MemReqValid),
    .MemReqSecond(MemReqSecond), .MemReqReady(MemReqReady), .MemRspValid(MemRspValid),
    .MemRspData(MemRspData), .RespValid(RespValid), .RespReady(RespReady),
    .RespData(RespData), .RespFault(RespFault)
  );

  // ---------------- XLEN=32, no split ----------------
  logic f_ReqValid, f_ReqReady, f_MemReqValid, f_MemReqSecond, f_MemReqReady;
  logic f_MemRspValid, f_RespValid, f_RespReady, f_RespFault;
  truncType f_ReqType;
  logic [1:0] f_ReqOffset;
  logic [31:0] f_MemRspData, f_RespData;

  misaligned_load_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) dut_f (
    .clk(clk), .reset_n(reset_n), .ReqValid(f_ReqValid), .ReqReady(f_ReqReady),
    .ReqType(f_ReqType), .ReqOffset(f_ReqOffset), .MemReqValid(f_MemReqValid),
    .MemReqSecond(f_MemReqSecond), .MemReqReady(f_MemReqReady), .MemRspValid(f_MemRspValid),
    .MemRspData(f_MemRspData), .RespValid(f_RespValid), .RespReady(f_RespReady),
    .RespData(f_RespData), .RespFault(f_RespFault)
  );

  // ---------------- XLEN=64, split ----------------
  logic w_ReqValid, w_ReqReady, w_MemReqValid, w_MemReqSecond, w_MemReqReady;
  logic w_MemRspValid, w_RespValid, w_RespReady, w_RespFault;
  truncType w_ReqType;
  logic [2:0] w_ReqOffset;
  logic [63:0] w_MemRspData, w_RespData;

  misaligned_load_unit #(.XLEN(64), .SPLIT_MISALIGNED(1'b1)) dut_w (
    .clk(clk), .reset_n(reset_n), .ReqValid(w_ReqValid), .ReqReady(w_ReqReady),
    .ReqType(w_ReqType), .ReqOffset(w_ReqOffset), .MemReqValid(w_MemReqValid),
    .MemReqSecond(w_MemReqSecond), .MemReqReady(w_MemReqReady), .MemRspValid(w_MemRspValid),
    .MemRspData(w_MemRspData), .RespValid(w_RespValid), .RespReady(w_RespReady),
    .RespData(w_RespData), .RespFault(w_RespFault)
  );

  // ---------------- memory model and scoreboard for the main DUT ----------------
  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;
  exp_t sb[$];

  logic [31:0] beat0 = '0, beat1 = '0;
  logic req_seen = 1'b0, req_sec = 1'b0;
  logic hold_second = 1'b0, rsp_inject = 1'b0;
  int mem_req_count = 0, mem_sec_count = 0;

  always @(negedge clk) begin
    req_seen = MemReqValid && MemReqReady;
    req_sec  = MemReqSecond;
    if (req_seen) begin
      mem_req_count++;
      if (MemReqSecond) mem_sec_count++;
    end
  end

  always @(posedge clk) begin
    #1;
    MemRspValid = (req_seen && !(req_sec && hold_second)) || rsp_inject;
    MemRspData  = req_sec ? beat1 : beat0;
  end

  always @(negedge clk) begin
    if (RespValid && RespReady) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 64'(RespValid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_data", 64'(RespData), 64'(e.data));
        check("resp_fault", 64'(RespFault), 64'(e.fault));
      end
    end
  end

  // Entered and left just after a rising edge with the main DUT idle.
  task automatic run_load(input truncType t, input logic [1:0] off,
                          input logic [31:0] b0, input logic [31:0] b1,
                          input logic [31:0] exp_data, input logic exp_fault,
                          input int exp_beats, input int exp_secs, input int exp_lat);
    int n, lat, req_base, sec_base;
    beat0 = b0; beat1 = b1;
    ReqValid = 1'b1; ReqType = t; ReqOffset = off; RespReady = 1'b1;
    n = 0;
    while (!ReqReady && n < 20) begin @(posedge clk); #1; n++; end
    check("req_ready", 64'(ReqReady), 64'd1);
    sb.push_back('{exp_data, exp_fault});
    req_base = mem_req_count; sec_base = mem_sec_count;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!RespValid && lat < 40) begin @(negedge clk); lat++; end
    check("latency", 64'(lat), 64'(exp_lat));
    check("beats", 64'(mem_req_count - req_base), 64'(exp_beats));
    check("second_beats", 64'(mem_sec_count - sec_base), 64'(exp_secs));
    @(posedge clk); #1;
  endtask

  task automatic f_fault(input truncType t, input logic [1:0] off);
    f_ReqValid = 1'b1; f_ReqType = t; f_ReqOffset = off; f_RespReady = 1'b1;
    check("f_req_ready", 64'(f_ReqReady), 64'd1);
    @(posedge clk); #1;
    f_ReqValid = 1'b0;
    @(negedge clk);
    check("f_resp_valid", 64'(f_RespValid), 64'd1);
    check("f_resp_fault", 64'(f_RespFault), 64'd1);
    check("f_resp_data", 64'(f_RespData), 64'd0);
    check("f_no_memreq", 64'(f_MemReqValid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("f_idle_memreq", 64'(f_MemReqValid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic f_load(input truncType t, input logic [1:0] off,
                        input logic [31:0] b0, input logic [31:0] exp_data);
    f_ReqValid = 1'b1; f_ReqType = t; f_ReqOffset = off; f_RespReady = 1'b1;
    @(posedge clk); #1;
    f_ReqValid = 1'b0;
    @(negedge clk);
    check("f_memreq", 64'(f_MemReqValid), 64'd1);
    @(posedge clk); #1;
    f_MemRspValid = 1'b1; f_MemRspData = b0;
    @(posedge clk); #1;
    f_MemRspValid = 1'b0;
    @(negedge clk);
    check("f_ok_valid", 64'(f_RespValid), 64'd1);
    check("f_ok_data", 64'(f_RespData), 64'(exp_data));
    check("f_ok_fault", 64'(f_RespFault), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic w_load(input truncType t, input logic [2:0] off,
                        input logic [63:0] b0, input logic [63:0] exp_data);
    w_ReqValid = 1'b1; w_ReqType = t; w_ReqOffset = off; w_RespReady = 1'b1;
    check("w_req_ready", 64'(w_ReqReady), 64'd1);
    @(posedge clk); #1;
    w_ReqValid = 1'b0;
    @(negedge clk);
    check("w_memreq", 64'(w_MemReqValid), 64'd1);
    @(posedge clk); #1;
    w_MemRspValid = 1'b1; w_MemRspData = b0;
    @(posedge clk); #1;
    w_MemRspValid = 1'b0;
    @(negedge clk);
    check("w_resp_valid", 64'(w_RespValid), 64'd1);
    check("w_resp_data", w_RespData, exp_data);
    check("w_resp_fault", 64'(w_RespFault), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0;
    ReqValid = 1'b0; ReqType = BYTE; ReqOffset = '0; MemReqReady = 1'b1; RespReady = 1'b1;
    f_ReqValid = 1'b0; f_ReqType = BYTE; f_ReqOffset = '0; f_MemReqReady = 1'b1;
    f_MemRspValid = 1'b0; f_MemRspData = '0; f_RespReady = 1'b1;
    w_ReqValid = 1'b0; w_ReqType = BYTE; w_ReqOffset = '0; w_MemReqReady = 1'b1;
    w_MemRspValid = 1'b0; w_MemRspData = '0; w_RespReady = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(ReqReady), 64'd1);
    check("rst_memreq", 64'(MemReqValid), 64'd0);
    check("rst_memsecond", 64'(MemReqSecond), 64'd0);
    check("rst_resp_valid", 64'(RespValid), 64'd0);
    check("rst_resp_data", 64'(RespData), 64'd0);
    check("rst_resp_fault", 64'(RespFault), 64'd0);
    check("rst_f_valid", 64'(f_RespValid), 64'd0);
    check("rst_w_valid", 64'(w_RespValid), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_load(WORD,               2'd0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 1, 0, 3);
    run_load(BYTE,               2'd3, 32'h80112233, 32'h0,        32'hFFFFFF80, 1'b0, 1, 0, 3);
    run_load(BYTE_UNSIGNED,      2'd3, 32'h80112233, 32'h0,        32'h00000080, 1'b0, 1, 0, 3);
    run_load(HALF_WORD,          2'd3, 32'hAB000000, 32'h000000CD, 32'hFFFFCDAB, 1'b0, 2, 1, 5);
    run_load(HALF_WORD,          2'd1, 32'h00ABCD00, 32'h0,        32'hFFFFABCD, 1'b0, 1, 0, 3);
    run_load(HALF_WORD_UNSIGNED, 2'd1, 32'h00F00F00, 32'h0,        32'h0000F00F, 1'b0, 1, 0, 3);
    run_load(WORD,               2'd2, 32'h11223344, 32'h55667788, 32'h77881122, 1'b0, 2, 1, 5);
    run_load(NO_TRUNC,           2'd1, 32'hAABBCCDD, 32'h11223344, 32'h44AABBCC, 1'b0, 2, 1, 5);
    run_load(WORD_UNSIGNED,      2'd0, 32'h12345678, 32'h0,        32'h00000000, 1'b1, 0, 0, 1);
    run_load(DOUBLE_WORD,        2'd0, 32'h12345678, 32'h0,        32'h00000000, 1'b1, 0, 0, 1);
    run_load(BYTE,               2'd2, 32'h00800000, 32'h0,        32'hFFFFFF80, 1'b0, 1, 0, 3);

    // Non-splitting unit: aligned load works, misaligned loads fault without beats.
    f_load(HALF_WORD, 2'd2, 32'h7FFF0000, 32'h00007FFF);
    f_fault(WORD, 2'd2);
    f_fault(HALF_WORD, 2'd1);

    // 64-bit unit.
    w_load(DOUBLE_WORD,   3'd0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);
    w_load(WORD,          3'd4, 64'h80000000_12345678, 64'hFFFFFFFF_80000000);
    w_load(WORD_UNSIGNED, 3'd4, 64'h80000000_12345678, 64'h00000000_80000000);
    w_load(NO_TRUNC,      3'd0, 64'hFEDCBA98_76543210, 64'hFEDCBA98_76543210);

    // Backpressure on the response, then a same-cycle handshake plus new request.
    beat0 = 32'h0000007F;
    RespReady = 1'b0; ReqValid = 1'b1; ReqType = BYTE; ReqOffset = 2'd0;
    sb.push_back('{32'h0000007F, 1'b0});
    @(posedge clk); #1;
    ReqValid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!RespValid && n < 20) begin @(negedge clk); n++; end
    check("hold_valid", 64'(RespValid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_data", 64'(RespData), 64'h7F);
      check("hold_valid_stable", 64'(RespValid), 64'd1);
      check("hold_req_ready", 64'(ReqReady), 64'd0);
    end
    @(posedge clk); #1;
    RespReady = 1'b1; ReqValid = 1'b1; ReqType = WORD; ReqOffset = 2'd0;
    sb.push_back('{32'h12345678, 1'b0});
    @(negedge clk);
    check("b2b_req_ready", 64'(ReqReady), 64'd1);
    beat0 = 32'h12345678;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    @(negedge clk);
    check("b2b_memreq", 64'(MemReqValid), 64'd1);
    check("b2b_resp_dropped", 64'(RespValid), 64'd0);
    n = 0;
    while (!RespValid && n < 20) begin @(negedge clk); n++; end
    check("b2b_resp_valid", 64'(RespValid), 64'd1);
    @(posedge clk); #1;
    check("b2b_drained", 64'(sb.size()), 64'd0);

    // Reset while waiting in RSP1, then a stray beat after release.
    hold_second = 1'b1; beat0 = 32'hAB000000; beat1 = 32'h000000CD;
    ReqValid = 1'b1; ReqType = HALF_WORD; ReqOffset = 2'd3; RespReady = 1'b1;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(MemReqValid && MemReqSecond) && n < 20) begin @(negedge clk); n++; end
    check("rst_second_req", 64'(MemReqSecond), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rsp1_waiting", 64'(MemReqValid | RespValid), 64'd0);
    reset_n = 1'b0;
    #1;
    check("abort_req_ready", 64'(ReqReady), 64'd1);
    check("abort_memreq", 64'(MemReqValid), 64'd0);
    check("abort_memsecond", 64'(MemReqSecond), 64'd0);
    check("abort_resp_valid", 64'(RespValid), 64'd0);
    check("abort_resp_data", 64'(RespData), 64'd0);
    check("abort_resp_fault", 64'(RespFault), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1; hold_second = 1'b0;
    @(negedge clk); rsp_inject = 1'b1;
    @(negedge clk); rsp_inject = 1'b0;
    @(negedge clk);
    check("stray_resp_valid", 64'(RespValid), 64'd0);
    check("stray_memreq", 64'(MemReqValid), 64'd0);
    check("stray_req_ready", 64'(ReqReady), 64'd1);
    check("stray_resp_data", 64'(RespData), 64'd0);
    @(posedge clk); #1;

    run_load(HALF_WORD, 2'd3, 32'hAB000000, 32'h000000CD, 32'hFFFFCDAB, 1'b0, 2, 1, 5);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
